// File: rtl/wb_icu186_pkg.sv
// Shared constants for the 80186-style interrupt control unit: register map,
// source ordering, control-register fields and reset values.
package icu186_pkg;

    localparam int NSRC  = 5;
    localparam int CON_W = 5;

    // Source index order doubles as the fixed tie-break order.
    typedef enum logic [2:0] {
        SRC_TMR = 3'd0,
        SRC_I0  = 3'd1,
        SRC_I1  = 3'd2,
        SRC_I2  = 3'd3,
        SRC_I3  = 3'd4
    } src_e;

    // Word offsets within the 0xFF20 block.
    localparam logic [3:0] ADR_EOI    = 4'h1;
    localparam logic [3:0] ADR_MASK   = 4'h4;
    localparam logic [3:0] ADR_PRIMSK = 4'h5;
    localparam logic [3:0] ADR_INSERV = 4'h6;
    localparam logic [3:0] ADR_REQST  = 4'h7;
    localparam logic [3:0] ADR_INTSTS = 4'h8;
    localparam logic [3:0] ADR_TCUCON = 4'h9;
    localparam logic [3:0] ADR_I0CON  = 4'hC;
    localparam logic [3:0] ADR_I1CON  = 4'hD;
    localparam logic [3:0] ADR_I2CON  = 4'hE;
    localparam logic [3:0] ADR_I3CON  = 4'hF;

    localparam int CON_MSK = 3;
    localparam int CON_LTM = 4;

    localparam logic [CON_W-1:0] CON_RST    = 5'h0F;
    localparam logic [2:0]       PRIMSK_RST = 3'd7;

    // Register bit map: [0]=timer, [7:4]=int3..int0.
    function automatic logic [15:0] map16(input logic [NSRC-1:0] v);
        return {8'h00, v[4:1], 3'b000, v[0]};
    endfunction

    function automatic logic [NSRC-1:0] unmap16(input logic [15:0] d);
        return {d[7:4], d[0]};
    endfunction

endpackage

// File: rtl/wb_icu186_sync_edge.sv
// Multi-flop synchroniser for an asynchronous request line with a
// rising-edge pulse on the synchronised level.
module icu_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/wb_icu186.sv
// 80186-style interrupt control unit on a Wishbone slave port: collects
// timer, int0..int3 and NMI requests, arbitrates and supplies the vector.
module wb_icu186
    import icu186_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int TMR_VEC      = 8,
    parameter int INT_VEC_BASE = 12,
    parameter int NMI_VEC      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic [3:0]  irq_i,
    input  logic        tmr_irq_i,
    input  logic        nmi_i,
    output logic        intr_o,
    input  logic        inta_i,
    output logic        nmi_o,
    input  logic        nmia_i,
    output logic [7:0]  vec_o
);

    logic [CON_W-1:0] con [NSRC];
    logic [2:0]       primsk;
    logic [NSRC-1:0]  inserv, reqst, inserv_n, reqst_n, msk;
    logic [NSRC-1:0]  src_lvl, src_rise, eoi_clr, wd_map;
    logic [3:0]       irq_lvl, irq_rise;
    logic             nmi_rise, nmi_level_unused;
    logic [6:0]       wb_dat_hi_unused;
    logic             served, acc, wr, wr_lo;
    logic             inta_prev, inta_rise, inta_act;
    logic [7:0]       vec_lat;
    logic             nmi_pend;
    logic             win_vld, isr_vld, intr_next;
    logic [2:0]       win_idx, win_pr, isr_idx, isr_pr;
    logic [3:0]       isr_lim;
    logic [15:0]      rdata;

    function automatic logic [7:0] src_vec(input logic [2:0] s);
        if (src_e'(s) == SRC_TMR)
            return 8'(TMR_VEC);
        return 8'(INT_VEC_BASE) + 8'(s) - 8'd1;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_irq_sync
        icu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst   (rst),
            .din   (irq_i[i]),
            .level (irq_lvl[i]),
            .rise  (irq_rise[i])
        );
    end

    icu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (nmi_i),
        .level (nmi_level_unused),
        .rise  (nmi_rise)
    );

    // The timer request is already synchronous; its pulse is its own edge.
    assign src_lvl          = {irq_lvl, tmr_irq_i};
    assign src_rise         = {irq_rise, tmr_irq_i};
    assign wd_map           = unmap16(wb_dat_i);
    assign wb_dat_hi_unused = wb_dat_i[14:8];

    // A new access needs stb/cyc to drop after each ack.
    assign acc       = wb_stb_i & wb_cyc_i & ~served & ~wb_ack_o;
    assign wr        = acc & wb_we_i;
    assign wr_lo     = wr & wb_sel_i[0];
    assign inta_rise = inta_i & ~inta_prev;

    always_comb begin
        win_vld = 1'b0;
        win_idx = 3'd0;
        win_pr  = 3'd7;
        isr_vld = 1'b0;
        isr_idx = 3'd0;
        isr_pr  = 3'd7;
        for (int s = 0; s < NSRC; s++) begin
            msk[s] = con[s][CON_MSK];
            if (reqst[s] && !con[s][CON_MSK] && (!win_vld || con[s][2:0] < win_pr)) begin
                win_vld = 1'b1;
                win_idx = 3'(s);
                win_pr  = con[s][2:0];
            end
            if (inserv[s] && (!isr_vld || con[s][2:0] < isr_pr)) begin
                isr_vld = 1'b1;
                isr_idx = 3'(s);
                isr_pr  = con[s][2:0];
            end
        end
        isr_lim   = isr_vld ? {1'b0, isr_pr} : 4'd8;
        intr_next = win_vld && (win_pr < primsk) && ({1'b0, win_pr} < isr_lim);
    end

    always_comb begin
        eoi_clr = '0;
        if (wr && wb_adr_i == ADR_EOI) begin
            if (wb_sel_i[1] && wb_dat_i[15]) begin
                if (isr_vld)
                    eoi_clr[isr_idx] = 1'b1;
            end else if (wb_sel_i[0]) begin
                for (int s = 0; s < NSRC; s++)
                    if (src_vec(3'(s)) == {3'b000, wb_dat_i[4:0]})
                        eoi_clr[s] = 1'b1;
            end
        end
    end

    // EOI lands before the acknowledge sets the new in-service bit;
    // hardware request edges override CPU writes to REQST.
    always_comb begin
        inserv_n = inserv;
        if (wr_lo && wb_adr_i == ADR_INSERV)
            inserv_n = wd_map;
        inserv_n = inserv_n & ~eoi_clr;
        if (inta_rise && win_vld)
            inserv_n[win_idx] = 1'b1;
        reqst_n = reqst;
        for (int s = 0; s < NSRC; s++) begin
            if (con[s][CON_LTM]) begin
                reqst_n[s] = src_lvl[s];
            end else begin
                if (wr_lo && wb_adr_i == ADR_REQST)
                    reqst_n[s] = wd_map[s];
                if (inta_rise && win_vld && win_idx == 3'(s))
                    reqst_n[s] = 1'b0;
                if (src_rise[s])
                    reqst_n[s] = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (wb_adr_i)
            ADR_MASK:   rdata = map16(msk);
            ADR_PRIMSK: rdata = {13'd0, primsk};
            ADR_INSERV: rdata = map16(inserv);
            ADR_REQST:  rdata = map16(reqst);
            ADR_TCUCON: rdata = {11'd0, con[0]};
            ADR_I0CON:  rdata = {11'd0, con[1]};
            ADR_I1CON:  rdata = {11'd0, con[2]};
            ADR_I2CON:  rdata = {11'd0, con[3]};
            ADR_I3CON:  rdata = {11'd0, con[4]};
            default:    rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            served   <= 1'b0;
            wb_dat_o <= 16'h0000;
        end else begin
            wb_ack_o <= acc;
            served   <= wb_stb_i & wb_cyc_i & (served | wb_ack_o);
            wb_dat_o <= (acc && !wb_we_i) ? rdata : 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSRC; s++)
                con[s] <= CON_RST;
            primsk <= PRIMSK_RST;
        end else if (wr_lo) begin
            case (wb_adr_i)
                ADR_MASK:
                    for (int s = 0; s < NSRC; s++)
                        con[s][CON_MSK] <= wd_map[s];
                ADR_PRIMSK: primsk <= wb_dat_i[2:0];
                ADR_TCUCON: con[0] <= wb_dat_i[4:0];
                ADR_I0CON:  con[1] <= wb_dat_i[4:0];
                ADR_I1CON:  con[2] <= wb_dat_i[4:0];
                ADR_I2CON:  con[3] <= wb_dat_i[4:0];
                ADR_I3CON:  con[4] <= wb_dat_i[4:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inserv    <= '0;
            reqst     <= '0;
            intr_o    <= 1'b0;
            inta_prev <= 1'b0;
            inta_act  <= 1'b0;
            vec_lat   <= 8'h00;
        end else begin
            inserv    <= inserv_n;
            reqst     <= reqst_n;
            intr_o    <= intr_next & ~inta_rise;
            inta_prev <= inta_i;
            if (inta_rise) begin
                inta_act <= 1'b1;
                vec_lat  <= win_vld ? src_vec(win_idx) : 8'(INT_VEC_BASE + 7);
            end else if (!inta_i) begin
                inta_act <= 1'b0;
            end
        end
    end

    // An NMI edge seen during its own acknowledge is replayed afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_o    <= 1'b0;
            nmi_pend <= 1'b0;
        end else if (nmia_i) begin
            nmi_o <= 1'b0;
            if (nmi_rise)
                nmi_pend <= 1'b1;
        end else if (nmi_rise || nmi_pend) begin
            nmi_o    <= 1'b1;
            nmi_pend <= 1'b0;
        end
    end

    assign vec_o = nmia_i              ? 8'(NMI_VEC) :
                   (inta_act & inta_i) ? vec_lat     : 8'h00;

endmodule

// File: tb/tb_wb_icu186.sv
// Directed bench for wb_icu186: register map, arbitration, acknowledge,
// EOI, NMI and asynchronous reset behaviour.
module tb_wb_icu186;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic [3:0]  irq_i = '0;
    logic        tmr_irq_i = 1'b0, nmi_i = 1'b0;
    logic        intr_o, inta_i = 1'b0, nmi_o, nmia_i = 1'b0;
    logic [7:0]  vec_o;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] A_EOI = 4'h1, A_MASK = 4'h4, A_PRIMSK = 4'h5, A_INSERV = 4'h6;
    localparam logic [3:0] A_REQST = 4'h7, A_INTSTS = 4'h8, A_TCUCON = 4'h9;
    localparam logic [3:0] A_I0CON = 4'hC, A_I1CON = 4'hD, A_I2CON = 4'hE;

    wb_icu186 dut (
        .clk       (clk),
        .rst       (rst),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_ack_o  (wb_ack_o),
        .irq_i     (irq_i),
        .tmr_irq_i (tmr_irq_i),
        .nmi_i     (nmi_i),
        .intr_o    (intr_o),
        .inta_i    (inta_i),
        .nmi_o     (nmi_o),
        .nmia_i    (nmia_i),
        .vec_o     (vec_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic [3:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                           input logic we, output logic [15:0] rd);
        logic got;
        got = 1'b0;
        rd  = 16'hxxxx;
        tick(1);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1);
            if (wb_ack_o) begin
                got = 1'b1;
                rd  = wb_dat_o;
            end
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got)
            chk("wb_ack_timeout", 16'd0, 16'd1);
    endtask

    task automatic wb_wr(input logic [3:0] adr, input logic [15:0] dat);
        logic [15:0] unused_rd;
        wb_xfer(adr, dat, 2'b11, 1'b1, unused_rd);
    endtask

    task automatic wb_rd_chk(input string tag, input logic [3:0] adr, input logic [15:0] exp);
        logic [15:0] rd;
        wb_xfer(adr, 16'h0000, 2'b11, 1'b0, rd);
        chk(tag, rd, exp);
    endtask

    task automatic wait_intr(input string tag);
        for (int i = 0; i < 12 && !intr_o; i++)
            tick(1);
        chk(tag, 16'(intr_o), 16'd1);
    endtask

    task automatic do_ack(input string tag, input logic [7:0] exp_vec);
        inta_i = 1'b1;
        tick(1);
        chk(tag, 16'(vec_o), 16'(exp_vec));
        chk({tag, "_intr_drop"}, 16'(intr_o), 16'd0);
        inta_i = 1'b0;
        tick(1);
    endtask

    task automatic pulse_irq(input logic [3:0] m);
        irq_i = m;
        tick(2);
        irq_i = 4'h0;
    endtask

    initial begin
        int n;
        tick(3);
        chk("rst_intr", 16'(intr_o), 16'd0);
        chk("rst_nmi", 16'(nmi_o), 16'd0);
        chk("rst_vec", 16'(vec_o), 16'd0);
        chk("rst_ack", 16'(wb_ack_o), 16'd0);
        rst = 1'b0;
        tick(1);

        wb_rd_chk("rst_mask", A_MASK, 16'h00F1);
        wb_rd_chk("rst_primsk", A_PRIMSK, 16'h0007);
        wb_rd_chk("rst_i0con", A_I0CON, 16'h000F);
        wb_rd_chk("rst_tcucon", A_TCUCON, 16'h000F);
        wb_rd_chk("intsts_zero", A_INTSTS, 16'h0000);

        // Upper-byte-only write must not touch I0CON.
        begin
            logic [15:0] rd;
            wb_xfer(A_I0CON, 16'h0000, 2'b10, 1'b1, rd);
        end
        wb_rd_chk("sel_gate_i0con", A_I0CON, 16'h000F);

        // Single int0 request, edge mode, PR0.
        wb_wr(A_I0CON, 16'h0000);
        wb_rd_chk("mask_alias", A_MASK, 16'h00E1);
        irq_i = 4'b0001;
        n = 0;
        for (int i = 1; i <= 10 && !intr_o; i++) begin
            tick(1);
            n = i;
            if (i == 2)
                irq_i = 4'h0;
        end
        irq_i = 4'h0;
        chk("int0_intr", 16'(intr_o), 16'd1);
        chk("int0_latency_ok", 16'(n <= 4), 16'd1);
        do_ack("int0_vec", 8'h0C);
        wb_rd_chk("int0_inserv", A_INSERV, 16'h0010);
        wb_rd_chk("int0_reqst", A_REQST, 16'h0000);
        wb_wr(A_EOI, 16'h000C);
        wb_rd_chk("int0_eoi", A_INSERV, 16'h0000);

        // Priority: int1 (PR1) beats int0 (PR3).
        wb_wr(A_I0CON, 16'h0003);
        wb_wr(A_I1CON, 16'h0001);
        pulse_irq(4'b0011);
        wait_intr("prio_intr");
        do_ack("prio_vec1", 8'h0D);
        tick(3);
        chk("prio_blocked", 16'(intr_o), 16'd0);
        wb_rd_chk("prio_reqst", A_REQST, 16'h0010);
        wb_wr(A_EOI, 16'h000D);
        wait_intr("prio_intr2");
        do_ack("prio_vec2", 8'h0C);
        wb_wr(A_EOI, 16'h000C);
        wb_rd_chk("prio_inserv_clr", A_INSERV, 16'h0000);

        // Equal priority in service blocks; non-specific EOI releases it.
        wb_wr(A_I0CON, 16'h0002);
        wb_wr(A_I2CON, 16'h0002);
        pulse_irq(4'b0001);
        wait_intr("eq_intr");
        do_ack("eq_vec0", 8'h0C);
        pulse_irq(4'b0100);
        tick(5);
        chk("eq_blocked", 16'(intr_o), 16'd0);
        wb_wr(A_EOI, 16'h8000);
        wait_intr("nspec_intr");
        do_ack("nspec_vec", 8'h0E);
        wb_wr(A_EOI, 16'h8000);
        wb_rd_chk("nspec_inserv_clr", A_INSERV, 16'h0000);

        // Priority mask against the timer.
        wb_wr(A_PRIMSK, 16'h0001);
        wb_wr(A_TCUCON, 16'h0001);
        tmr_irq_i = 1'b1;
        tick(1);
        tmr_irq_i = 1'b0;
        tick(3);
        chk("primsk_blocked", 16'(intr_o), 16'd0);
        wb_rd_chk("tmr_reqst", A_REQST, 16'h0001);
        wb_wr(A_PRIMSK, 16'h0002);
        wait_intr("tmr_intr");
        do_ack("tmr_vec", 8'h08);
        wb_wr(A_EOI, 16'h0008);
        wb_wr(A_PRIMSK, 16'h0007);

        // Acknowledge with nothing pending returns the spurious vector.
        do_ack("spurious_vec", 8'h13);
        wb_rd_chk("spurious_inserv", A_INSERV, 16'h0000);

        // NMI while int0 is pending.
        wb_wr(A_I0CON, 16'h0000);
        pulse_irq(4'b0001);
        wait_intr("nmi_int0_pend");
        nmi_i = 1'b1;
        tick(2);
        nmi_i = 1'b0;
        for (int i = 0; i < 10 && !nmi_o; i++)
            tick(1);
        chk("nmi_set", 16'(nmi_o), 16'd1);
        nmia_i = 1'b1;
        #1;
        chk("nmi_vec", 16'(vec_o), 16'h0002);
        tick(1);
        chk("nmi_clr", 16'(nmi_o), 16'd0);
        chk("nmi_intr_kept", 16'(intr_o), 16'd1);
        nmia_i = 1'b0;
        #1;
        chk("nmi_vec_off", 16'(vec_o), 16'h0000);

        // Reset in the middle of an acknowledge and a bus read.
        nmi_i = 1'b1;
        tick(2);
        nmi_i = 1'b0;
        for (int i = 0; i < 10 && !nmi_o; i++)
            tick(1);
        inta_i = 1'b1;
        tick(1);
        chk("mid_vec", 16'(vec_o), 16'h000C);
        wb_adr_i = A_MASK;
        wb_sel_i = 2'b11;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        tick(1);
        chk("mid_ack", 16'(wb_ack_o), 16'd1);
        chk("mid_dat", wb_dat_o, 16'h0080);
        chk("mid_nmi", 16'(nmi_o), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ack", 16'(wb_ack_o), 16'd0);
        chk("arst_dat", wb_dat_o, 16'h0000);
        chk("arst_intr", 16'(intr_o), 16'd0);
        chk("arst_nmi", 16'(nmi_o), 16'd0);
        chk("arst_vec", 16'(vec_o), 16'd0);
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        inta_i   = 1'b0;
        tick(2);
        rst = 1'b0;
        wb_rd_chk("post_rst_mask", A_MASK, 16'h00F1);
        wb_rd_chk("post_rst_i0con", A_I0CON, 16'h000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
